// File: rtl/iris_pkg.sv
// -----------------------------------------------------------------------------
// iris_pkg
// Shared definitions for the random-number / histogram datapath.
//   - default seed/taps and sample-count widths
//   - histogram geometry (bin count) and input-to-update latency, which the
//     histogram instance and the run sequencer must agree on
//   - run sequencer state encoding
// -----------------------------------------------------------------------------
package iris_pkg;

    localparam int IRIS_DATA_WIDTH = 32;   // LFSR seed / tap-mask width
    localparam int IRIS_CNT_WIDTH  = 16;   // samples-per-run counter width
    localparam int IRIS_NUM_BINS   = 8;    // histogram bins (power of two)
    localparam int IRIS_HIST_LAT   = 2;    // histogram input-to-update latency

    // Run sequencer states, in the order a normal run visits them.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SEED  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/lfsr_hist_sequencer.sv
// -----------------------------------------------------------------------------
// lfsr_hist_sequencer
// Run controller between the AXI-Lite register block and the LFSR/histogram
// pair. One accepted start produces the sequence:
//   CLEAR (sweep every bin) -> SEED (load strobe) -> RUN (N enable cycles)
//   -> DRAIN (let the histogram pipeline settle) -> DONE (one-cycle pulse)
// A stop request aborts the sequence; configuration is only looked at in IDLE.
//
// Ports
//   aclk, areset        clock, asynchronous active-high reset
//   cfg_start           start request (level, sampled in IDLE only)
//   cfg_stop            abort request (level)
//   cfg_seed/taps/count run configuration, latched when a start is accepted
//   lfsr_load           one-cycle seed/taps load strobe
//   lfsr_seed/taps      seed and tap mask latched at start
//   lfsr_en             LFSR advance enable
//   hist_en             histogram accumulate enable (lfsr_en one cycle later)
//   hist_clr            bin clear strobe, hist_clr_idx = bin being cleared
//   busy                high in CLEAR, SEED, RUN and DRAIN
//   done                one-cycle completion pulse
//   aborted             last run ended by stop (sticky until next accepted start)
//   cfg_err             last start rejected for taps==0 (sticky likewise)
//   samples_done        lfsr_en cycles issued in the current/last run
//
// Every output comes straight from a register. The next-state logic computes
// the output values that belong to the *next* state, so outputs and state
// change on the same edge and no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module lfsr_hist_sequencer
    import iris_pkg::*;
#(
    parameter int DATA_WIDTH = IRIS_DATA_WIDTH,
    parameter int CNT_WIDTH  = IRIS_CNT_WIDTH,
    parameter int NUM_BINS   = IRIS_NUM_BINS,
    parameter int HIST_LAT   = IRIS_HIST_LAT
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        cfg_start,
    input  logic                        cfg_stop,
    input  logic [DATA_WIDTH-1:0]       cfg_seed,
    input  logic [DATA_WIDTH-1:0]       cfg_taps,
    input  logic [CNT_WIDTH-1:0]        cfg_count,
    output logic                        lfsr_load,
    output logic [DATA_WIDTH-1:0]       lfsr_seed,
    output logic [DATA_WIDTH-1:0]       lfsr_taps,
    output logic                        lfsr_en,
    output logic                        hist_en,
    output logic                        hist_clr,
    output logic [$clog2(NUM_BINS)-1:0] hist_clr_idx,
    output logic                        busy,
    output logic                        done,
    output logic                        aborted,
    output logic                        cfg_err,
    output logic [CNT_WIDTH-1:0]        samples_done
);

    localparam int IDX_W = $clog2(NUM_BINS);
    localparam int DRN_W = $clog2(HIST_LAT + 1);

    localparam logic [IDX_W-1:0] LAST_BIN  = IDX_W'(NUM_BINS - 1);
    // The drain counter runs HIST_LAT-1 .. 0, one DRAIN cycle per value.
    localparam logic [DRN_W-1:0] DRAIN_TOP = DRN_W'(HIST_LAT - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    seq_state_t             r_state;
    logic [DATA_WIDTH-1:0]  r_seed;
    logic [DATA_WIDTH-1:0]  r_taps;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [CNT_WIDTH-1:0]   r_samples;
    logic [IDX_W-1:0]       r_clr_idx;
    logic [DRN_W-1:0]       r_drain_cnt;
    logic                   r_hist_clr;
    logic                   r_lfsr_load;
    logic                   r_lfsr_en;
    logic                   r_hist_en;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_aborted;
    logic                   r_cfg_err;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    seq_state_t             w_state_next;
    logic [DATA_WIDTH-1:0]  w_seed_next;
    logic [DATA_WIDTH-1:0]  w_taps_next;
    logic [CNT_WIDTH-1:0]   w_count_next;
    logic [CNT_WIDTH-1:0]   w_samples_next;
    logic [IDX_W-1:0]       w_clr_idx_next;
    logic [DRN_W-1:0]       w_drain_cnt_next;
    logic                   w_hist_clr_next;
    logic                   w_lfsr_load_next;
    logic                   w_lfsr_en_next;
    logic                   w_busy_next;
    logic                   w_done_next;
    logic                   w_aborted_next;
    logic                   w_cfg_err_next;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state     <= ST_IDLE;
            r_seed      <= '0;
            r_taps      <= '0;
            r_count     <= '0;
            r_samples   <= '0;
            r_clr_idx   <= '0;
            r_drain_cnt <= '0;
            r_hist_clr  <= 1'b0;
            r_lfsr_load <= 1'b0;
            r_lfsr_en   <= 1'b0;
            r_hist_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_seed      <= w_seed_next;
            r_taps      <= w_taps_next;
            r_count     <= w_count_next;
            r_samples   <= w_samples_next;
            r_clr_idx   <= w_clr_idx_next;
            r_drain_cnt <= w_drain_cnt_next;
            r_hist_clr  <= w_hist_clr_next;
            r_lfsr_load <= w_lfsr_load_next;
            r_lfsr_en   <= w_lfsr_en_next;
            // The histogram sees each LFSR output one cycle after the advance
            // that produced it, so its enable is a plain one-cycle delay.
            r_hist_en   <= r_lfsr_en;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_aborted   <= w_aborted_next;
            r_cfg_err   <= w_cfg_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // Latched configuration, counters and sticky flags hold by default;
        // strobes and the clear index fall back to zero.
        w_state_next     = r_state;
        w_seed_next      = r_seed;
        w_taps_next      = r_taps;
        w_count_next     = r_count;
        w_samples_next   = r_samples;
        w_clr_idx_next   = '0;
        w_drain_cnt_next = r_drain_cnt;
        w_hist_clr_next  = 1'b0;
        w_lfsr_load_next = 1'b0;
        w_lfsr_en_next   = 1'b0;
        w_busy_next      = 1'b0;
        w_done_next      = 1'b0;
        w_aborted_next   = r_aborted;
        w_cfg_err_next   = r_cfg_err;

        case (r_state)
            ST_IDLE: begin
                // A simultaneous stop cancels the start outright: no run and
                // no flag update, not even cfg_err.
                if (cfg_start && !cfg_stop) begin
                    if (cfg_taps == '0) begin
                        // An all-zero tap mask would lock the LFSR; refuse it.
                        w_cfg_err_next = 1'b1;
                    end else begin
                        w_seed_next     = cfg_seed;
                        w_taps_next     = cfg_taps;
                        w_count_next    = cfg_count;
                        w_samples_next  = '0;
                        w_aborted_next  = 1'b0;
                        w_cfg_err_next  = 1'b0;
                        w_state_next    = ST_CLEAR;
                        w_hist_clr_next = 1'b1;
                        w_busy_next     = 1'b1;
                    end
                end
            end

            ST_CLEAR: begin
                if (cfg_stop) begin
                    // Abort before the load strobe: the LFSR is never touched.
                    w_state_next   = ST_DONE;
                    w_aborted_next = 1'b1;
                    w_samples_next = '0;
                    w_done_next    = 1'b1;
                end else if (r_clr_idx == LAST_BIN) begin
                    w_state_next     = ST_SEED;
                    w_lfsr_load_next = 1'b1;
                    w_busy_next      = 1'b1;
                end else begin
                    w_clr_idx_next  = r_clr_idx + IDX_W'(1);
                    w_hist_clr_next = 1'b1;
                    w_busy_next     = 1'b1;
                end
            end

            ST_SEED: begin
                if (cfg_stop) begin
                    w_state_next   = ST_DONE;
                    w_aborted_next = 1'b1;
                    w_samples_next = '0;
                    w_done_next    = 1'b1;
                end else if (r_count == '0) begin
                    // Zero-length run: nothing enters the histogram, so there
                    // is nothing to drain either.
                    w_state_next = ST_DONE;
                    w_done_next  = 1'b1;
                end else begin
                    w_state_next   = ST_RUN;
                    w_lfsr_en_next = 1'b1;
                    w_busy_next    = 1'b1;
                    w_samples_next = CNT_WIDTH'(1);
                end
            end

            ST_RUN: begin
                // r_samples already counts the enable being issued this cycle,
                // so reaching r_count here means the last sample is going out
                // now. A stop seen in this cycle does not withdraw its enable.
                if (cfg_stop || (r_samples == r_count)) begin
                    w_state_next     = ST_DRAIN;
                    w_busy_next      = 1'b1;
                    w_drain_cnt_next = DRAIN_TOP;
                    if (cfg_stop) begin
                        w_aborted_next = 1'b1;
                    end
                end else begin
                    w_lfsr_en_next = 1'b1;
                    w_busy_next    = 1'b1;
                    w_samples_next = r_samples + CNT_WIDTH'(1);
                end
            end

            ST_DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_state_next = ST_DONE;
                    w_done_next  = 1'b1;
                end else begin
                    w_drain_cnt_next = r_drain_cnt - DRN_W'(1);
                    w_busy_next      = 1'b1;
                end
            end

            ST_DONE: begin
                // Always pass through IDLE so a held start restarts after
                // exactly one idle cycle.
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign lfsr_load    = r_lfsr_load;
    assign lfsr_seed    = r_seed;
    assign lfsr_taps    = r_taps;
    assign lfsr_en      = r_lfsr_en;
    assign hist_en      = r_hist_en;
    assign hist_clr     = r_hist_clr;
    assign hist_clr_idx = r_clr_idx;
    assign busy         = r_busy;
    assign done         = r_done;
    assign aborted      = r_aborted;
    assign cfg_err      = r_cfg_err;
    assign samples_done = r_samples;

endmodule

// File: tb/tb_lfsr_hist_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lfsr_hist_sequencer
// Directed runs with hand-computed expectations. The stimulus thread pushes
// the expected result of every run that should complete; the monitor watches
// the DUT every cycle, accumulates what the run did, and compares against the
// queue head whenever done pulses.
// -----------------------------------------------------------------------------
module tb_lfsr_hist_sequencer;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int NB = 8;
    localparam int HL = 2;

    logic              aclk = 1'b0;
    logic              areset;
    logic              cfg_start;
    logic              cfg_stop;
    logic [DW-1:0]     cfg_seed;
    logic [DW-1:0]     cfg_taps;
    logic [CW-1:0]     cfg_count;
    logic              lfsr_load;
    logic [DW-1:0]     lfsr_seed;
    logic [DW-1:0]     lfsr_taps;
    logic              lfsr_en;
    logic              hist_en;
    logic              hist_clr;
    logic [2:0]        hist_clr_idx;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              cfg_err;
    logic [CW-1:0]     samples_done;

    lfsr_hist_sequencer #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW),
        .NUM_BINS   (NB),
        .HIST_LAT   (HL)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .cfg_start    (cfg_start),
        .cfg_stop     (cfg_stop),
        .cfg_seed     (cfg_seed),
        .cfg_taps     (cfg_taps),
        .cfg_count    (cfg_count),
        .lfsr_load    (lfsr_load),
        .lfsr_seed    (lfsr_seed),
        .lfsr_taps    (lfsr_taps),
        .lfsr_en      (lfsr_en),
        .hist_en      (hist_en),
        .hist_clr     (hist_clr),
        .hist_clr_idx (hist_clr_idx),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .cfg_err      (cfg_err),
        .samples_done (samples_done)
    );

    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int txn      = 0;

    always @(posedge aclk) cyc++;

    // Expected outcome of one completed run. lat is measured from the first
    // busy cycle to the done cycle; gap (if >= 0) from the previous done to
    // this run's first busy cycle.
    typedef struct {
        int          lat;
        int          gap;
        int          en;
        int          clr;
        int          load;
        int          samp;
        int          ab;
        int          ce;
        logic [31:0] seed;
        logic [31:0] taps;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t mk(int lat, int gap, int en, int clr, int load, int samp,
                                int ab, int ce, logic [31:0] sd, logic [31:0] tp);
        exp_t e;
        e.lat = lat; e.gap = gap; e.en = en; e.clr = clr; e.load = load;
        e.samp = samp; e.ab = ab; e.ce = ce; e.seed = sd; e.taps = tp;
        return e;
    endfunction

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
                     nm, act, act, req, req, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    logic prev_busy = 1'b0;
    logic prev_en   = 1'b0;
    int   start_cyc = 0;
    int   last_done = -1;
    int   run_gap   = -1;
    int   cnt_en    = 0;
    int   cnt_hist  = 0;
    int   cnt_load  = 0;
    int   cnt_clr   = 0;
    int   clr_err   = 0;
    int   align_err = 0;
    exp_t e_cur;

    always @(negedge aclk) begin
        if (areset) begin
            prev_busy = 1'b0;
            prev_en   = 1'b0;
            last_done = -1;
        end else begin
            if (busy && !prev_busy) begin
                start_cyc = cyc;
                run_gap   = (last_done >= 0) ? (cyc - last_done) : -1;
                cnt_en = 0; cnt_hist = 0; cnt_load = 0; cnt_clr = 0;
                clr_err = 0; align_err = 0;
            end
            if (hist_en != prev_en) align_err++;
            if (lfsr_en)   cnt_en++;
            if (hist_en)   cnt_hist++;
            if (lfsr_load) cnt_load++;
            if (hist_clr) begin
                if (int'(hist_clr_idx) != (cnt_clr % NB)) clr_err++;
                cnt_clr++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 with no run outstanding, required done=0 at cycle %0d", cyc);
                end else begin
                    e_cur = exp_q.pop_front();
                    txn++;
                    chk("latency",         cyc - start_cyc, e_cur.lat);
                    if (e_cur.gap >= 0) chk("restart_gap", run_gap, e_cur.gap);
                    chk("lfsr_en_cycles",  cnt_en,       e_cur.en);
                    chk("hist_en_cycles",  cnt_hist,     e_cur.en);
                    chk("hist_en_offset",  align_err,    0);
                    chk("clr_cycles",      cnt_clr,      e_cur.clr);
                    chk("clr_idx_order",   clr_err,      0);
                    chk("load_strobes",    cnt_load,     e_cur.load);
                    chk("samples_done",    samples_done, e_cur.samp);
                    chk("aborted",         aborted,      e_cur.ab);
                    chk("cfg_err",         cfg_err,      e_cur.ce);
                    chk("busy_at_done",    busy,         0);
                    chk("lfsr_seed",       lfsr_seed,    e_cur.seed);
                    chk("lfsr_taps",       lfsr_taps,    e_cur.taps);
                    $display("TXN %0d: done at cycle %0d lat=%0d en=%0d hist=%0d clr=%0d load=%0d samples=%0d aborted=%0d cfg_err=%0d seed=0x%0h",
                             txn, cyc, cyc - start_cyc, cnt_en, cnt_hist, cnt_clr, cnt_load,
                             samples_done, aborted, cfg_err, lfsr_seed);
                end
                last_done = cyc;
            end
            prev_busy = busy;
            prev_en   = lfsr_en;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all start and end at posedge + 1)
    // ------------------------------------------------------------------
    task automatic start_pulse(input logic [31:0] sd, input logic [31:0] tp, input logic [15:0] n);
        cfg_seed  = sd;
        cfg_taps  = tp;
        cfg_count = n;
        cfg_start = 1'b1;
        @(posedge aclk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_q(input int target);
        int n = 0;
        while (exp_q.size() > target && n < 400) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("runs_outstanding", exp_q.size(), target);
        while (exp_q.size() > target) void'(exp_q.pop_back());
    endtask

    task automatic wait_en(input int k);
        int n = 0;
        while (!(lfsr_en && samples_done == CW'(k)) && n < 300) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("run_reaches_sample", {lfsr_en, samples_done}, {1'b1, CW'(k)});
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 50) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("restart_busy", busy, 1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_seed"},    lfsr_seed,    0);
        chk({nm, "_taps"},    lfsr_taps,    0);
        chk({nm, "_samples"}, samples_done, 0);
        chk({nm, "_flags"},
            {lfsr_load, lfsr_en, hist_en, hist_clr, hist_clr_idx, busy, done, aborted, cfg_err}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        areset    = 1'b1;
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        cfg_seed  = '0;
        cfg_taps  = '0;
        cfg_count = '0;
        repeat (3) @(posedge aclk);
        #1;
        chk_zero("in_reset");
        areset = 1'b0;
        @(posedge aclk); #1;
        chk_zero("after_reset");

        // Basic run, N=4: 8 clears, 1 load, 4 enables, done 16 after t0.
        exp_q.push_back(mk(15, -1, 4, 8, 1, 4, 0, 0, 32'h1D, 32'h1D));
        start_pulse(32'h1D, 32'h1D, 16'd4);
        wait_q(0);
        repeat (2) @(posedge aclk);
        #1;

        // N=0: clear and load only, done 10 after t0.
        exp_q.push_back(mk(9, -1, 0, 8, 1, 0, 0, 0, 32'h5A5A, 32'h8000_0057));
        start_pulse(32'h5A5A, 32'h8000_0057, 16'd0);
        wait_q(0);
        repeat (2) @(posedge aclk);
        #1;

        // N=100 stopped in the 10th RUN cycle: 10 enables, drain, done.
        exp_q.push_back(mk(21, -1, 10, 8, 1, 10, 1, 0, 32'h1234, 32'hB4));
        start_pulse(32'h1234, 32'hB4, 16'd100);
        wait_en(10);
        cfg_stop = 1'b1;
        @(posedge aclk); #1;
        cfg_stop = 1'b0;
        wait_q(0);
        repeat (2) @(posedge aclk);
        #1;

        // Start and stop together (with a bad tap mask): nothing may change.
        cfg_taps  = '0;
        cfg_start = 1'b1;
        cfg_stop  = 1'b1;
        @(posedge aclk); #1;
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("startstop_busy",    busy,         0);
        chk("startstop_aborted", aborted,      1);
        chk("startstop_cfg_err", cfg_err,      0);
        chk("samples_hold",      samples_done, 10);

        // taps==0 rejected, then a good start clears the sticky flags.
        start_pulse(32'h1D, 32'h0, 16'd4);
        chk("reject_cfg_err", cfg_err, 1);
        chk("reject_busy",    busy,    0);
        repeat (3) @(posedge aclk);
        #1;
        chk("reject_idle",    {busy, hist_clr, lfsr_load}, 0);
        chk("reject_aborted", aborted, 1);
        exp_q.push_back(mk(14, -1, 3, 8, 1, 3, 0, 0, 32'h77, 32'h1D));
        start_pulse(32'h77, 32'h1D, 16'd3);
        wait_q(0);
        repeat (2) @(posedge aclk);
        #1;

        // Reset in the middle of RUN: outputs clear at once, no done follows.
        start_pulse(32'h99, 32'h1D, 16'd50);
        wait_en(5);
        @(posedge aclk);
        #2;
        areset = 1'b1;
        #1;
        chk_zero("reset_midrun");
        @(posedge aclk);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        repeat (30) @(posedge aclk);
        #1;
        chk("post_reset_busy", busy, 0);

        // Mid-run config writes are ignored; a held start restarts after one
        // idle cycle and picks up the new configuration.
        exp_q.push_back(mk(17, -1, 6, 8, 1, 6, 0, 0, 32'h1D, 32'h1D));
        exp_q.push_back(mk(13, 2, 2, 8, 1, 2, 0, 0, 32'hABCD, 32'h3));
        cfg_seed  = 32'h1D;
        cfg_taps  = 32'h1D;
        cfg_count = 16'd6;
        cfg_start = 1'b1;
        wait_en(2);
        cfg_seed  = 32'hABCD;
        cfg_taps  = 32'h3;
        cfg_count = 16'd2;
        chk("midrun_seed", lfsr_seed, 32'h1D);
        wait_q(1);
        wait_busy();
        cfg_start = 1'b0;
        wait_q(0);
        repeat (3) @(posedge aclk);
        #1;
        chk("final_idle", {busy, done}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
